// File: rtl/led_pio_blink_if.sv
// Avalon-MM s1 slave bus for the LED PIO: word address, chip select,
// active-low write strobe, 32-bit write data and zero-wait-state read data.
interface led_pio_blink_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/led_pio_blink.sv
// LED bank output PIO: DATA register with atomic set/clear, per-bit blink
// gated by a shared prescaled phase, and readback of the driven pins.
module led_pio_blink #(
   parameter int unsigned WIDTH        = 10,
   parameter int unsigned PERIOD_W     = 26,
   parameter logic [31:0] RESET_DATA   = 32'd0,
   parameter logic [31:0] RESET_PERIOD = 32'd25000000
) (
   input  logic             clk,
   input  logic             reset_n,
   led_pio_blink_if.slave   s1,
   output logic [WIDTH-1:0] out_port
);

   localparam logic [WIDTH-1:0]    RST_DATA   = RESET_DATA[WIDTH-1:0];
   localparam logic [PERIOD_W-1:0] RST_PERIOD = RESET_PERIOD[PERIOD_W-1:0];

   localparam logic [2:0] A_DATA     = 3'd0;
   localparam logic [2:0] A_BLINK_EN = 3'd1;
   localparam logic [2:0] A_PERIOD   = 3'd2;
   localparam logic [2:0] A_STATUS   = 3'd3;
   localparam logic [2:0] A_OUTSET   = 3'd4;
   localparam logic [2:0] A_OUTCLEAR = 3'd5;
   localparam logic [2:0] A_PINS     = 3'd6;

   logic [WIDTH-1:0]    r_data;
   logic [WIDTH-1:0]    r_blink_en;
   logic [PERIOD_W-1:0] r_period;
   logic [PERIOD_W-1:0] r_cnt;
   logic                r_phase;

   logic                w_wr;
   logic                w_period_wr;
   logic                w_wrap;
   logic [WIDTH-1:0]    w_wd_bits;
   logic [PERIOD_W-1:0] w_wd_period;
   logic                w_unused;

   assign w_wr        = s1.chipselect & ~s1.write_n;
   assign w_period_wr = w_wr && (s1.address == A_PERIOD);
   assign w_wd_bits   = s1.writedata[WIDTH-1:0];
   assign w_wd_period = s1.writedata[PERIOD_W-1:0];
   assign w_wrap      = (r_cnt == (r_period - PERIOD_W'(1)));
   assign w_unused    = ^s1.writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data     <= RST_DATA;
         r_blink_en <= '0;
         r_period   <= RST_PERIOD;
      end else if (w_wr) begin
         case (s1.address)
            A_DATA:     r_data     <= w_wd_bits;
            A_BLINK_EN: r_blink_en <= w_wd_bits;
            A_PERIOD:   r_period   <= w_wd_period;
            A_OUTSET:   r_data     <= r_data | w_wd_bits;
            A_OUTCLEAR: r_data     <= r_data & ~w_wd_bits;
            default:    ;
         endcase
      end
   end

   // A PERIOD write restarts the half-period even if it lands on a wrap edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_phase <= 1'b1;
      end else if (w_period_wr || (r_period == '0)) begin
         r_cnt   <= '0;
         r_phase <= 1'b1;
      end else if (w_wrap) begin
         r_cnt   <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_cnt   <= r_cnt + PERIOD_W'(1);
      end
   end

   assign out_port = r_data & (~r_blink_en | {WIDTH{r_phase}});

   always_comb begin
      s1.readdata = '0;
      case (s1.address)
         A_DATA:     s1.readdata[WIDTH-1:0]    = r_data;
         A_BLINK_EN: s1.readdata[WIDTH-1:0]    = r_blink_en;
         A_PERIOD:   s1.readdata[PERIOD_W-1:0] = r_period;
         A_STATUS:   s1.readdata[0]            = r_phase;
         A_PINS:     s1.readdata[WIDTH-1:0]    = out_port;
         default:    s1.readdata = '0;
      endcase
   end

endmodule
